regfile_port_arbiter: RTL



---
 rtl/regarb_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 61 ++++++
 rtl/regfile_port_arbiter.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/regarb_pkg.sv
// Shared constants and types for the register-file port arbiter.
package regarb_pkg;

    localparam int AW           = 6;
    localparam int DW           = 32;
    localparam int DEPTH        = 64;
    localparam int RESP_LATENCY = 1;

    typedef enum logic {
        ST_ARB   = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: grants the first valid requester at or above the pointer,
// wrapping modulo N_REQ; the pointer moves past the winner only when advance is set.
module rr_arbiter #(
    parameter int N_REQ = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_REQ-1:0]           valid,
    input  logic                       advance,
    output logic [N_REQ-1:0]           grant,
    output logic [$clog2(N_REQ)-1:0]   grant_idx,
    output logic [$clog2(N_REQ)-1:0]   ptr
);

    localparam int PW = $clog2(N_REQ);

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    logic [PW:0]   cand_sum;
    logic [PW-1:0] cand_idx;
    logic          found;

    always_comb begin
        grant     = '0;
        grant_idx = ptr_q;
        found     = 1'b0;
        cand_sum  = '0;
        cand_idx  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            // One extra bit so ptr+k never overflows before the wrap test.
            cand_sum = {1'b0, ptr_q} + (PW+1)'(k);
            if (cand_sum >= (PW+1)'(N_REQ)) begin
                cand_sum = cand_sum - (PW+1)'(N_REQ);
            end
            cand_idx = cand_sum[PW-1:0];
            if (!found && valid[cand_idx]) begin
                found           = 1'b1;
                grant[cand_idx] = 1'b1;
                grant_idx       = cand_idx;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance) begin
            ptr_d = (grant_idx == PW'(N_REQ-1)) ? '0 : grant_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/regfile_port_arbiter.sv
// Shares one read and one write port of a register file among N_REQ requesters.
// Optional hardware clear sequencer enabled by defining REGARB_CLEAR_EN.
module regfile_port_arbiter #(
    parameter int N_REQ = 4,
    parameter int AW    = regarb_pkg::AW,
    parameter int DW    = regarb_pkg::DW,
    parameter int DEPTH = regarb_pkg::DEPTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [N_REQ-1:0]      req_we,
    input  logic [N_REQ*AW-1:0]   req_addr,
    input  logic [N_REQ*DW-1:0]   req_wdata,
    output logic [N_REQ-1:0]      req_ready,
    output logic [N_REQ-1:0]      resp_valid,
    output logic [DW-1:0]         resp_rdata,
    output logic [AW-1:0]         rf_raddr,
    input  logic [DW-1:0]         rf_rdata,
    output logic [AW-1:0]         rf_waddr,
    output logic [DW-1:0]         rf_wdin,
    output logic                  rf_wena,
    input  logic                  clear_start,
    output logic                  clear_busy
);

    import regarb_pkg::*;

    localparam int PW = $clog2(N_REQ);

    logic [AW-1:0]    addr_arr  [N_REQ];
    logic [DW-1:0]    wdata_arr [N_REQ];

    logic [N_REQ-1:0] grant;
    logic [PW-1:0]    grant_idx;
    logic [PW-1:0]    rr_ptr;
    logic [PW-1:0]    sel;
    logic             arb_en;
    logic             transfer;
    logic             clearing;
    logic [AW-1:0]    clear_cnt;

    logic [N_REQ-1:0] resp_valid_q;
    logic [N_REQ-1:0] resp_valid_d;
    logic [DW-1:0]    resp_rdata_q;
    logic [DW-1:0]    resp_rdata_d;

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign addr_arr[gi]  = req_addr[gi*AW +: AW];
            assign wdata_arr[gi] = req_wdata[gi*DW +: DW];
        end
    endgenerate

    rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_rr_arbiter (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid     (req_valid),
        .advance   (transfer),
        .grant     (grant),
        .grant_idx (grant_idx),
        .ptr       (rr_ptr)
    );

`ifdef REGARB_CLEAR_EN
    state_t        state_q;
    state_t        state_d;
    logic [AW-1:0] clear_cnt_q;
    logic [AW-1:0] clear_cnt_d;

    always_comb begin
        state_d     = state_q;
        clear_cnt_d = clear_cnt_q;
        case (state_q)
            ST_ARB: begin
                if (clear_start) begin
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                if (clear_cnt_q == AW'(DEPTH-1)) begin
                    clear_cnt_d = '0;
                    state_d     = ST_ARB;
                end else begin
                    clear_cnt_d = clear_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d     = ST_ARB;
                clear_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_ARB;
            clear_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            clear_cnt_q <= clear_cnt_d;
        end
    end

    // A clear request in the same cycle as a request blocks that grant.
    assign arb_en     = (state_q == ST_ARB) && !clear_start;
    assign clearing   = (state_q == ST_CLEAR);
    assign clear_cnt  = clear_cnt_q;
    assign clear_busy = clearing;
`else
    assign arb_en     = 1'b1;
    assign clearing   = 1'b0;
    assign clear_cnt  = '0;
    assign clear_busy = clear_start & 1'b0;
`endif

    assign req_ready = (rst_n && arb_en) ? grant : '0;
    assign transfer  = |req_ready;
    assign sel       = transfer ? grant_idx : rr_ptr;

    always_comb begin
        rf_raddr = addr_arr[sel];
        rf_waddr = addr_arr[sel];
        rf_wdin  = wdata_arr[sel];
        rf_wena  = transfer && req_we[sel];
        if (clearing) begin
            rf_waddr = clear_cnt;
            rf_wdin  = '0;
            rf_wena  = rst_n;
        end
    end

    always_comb begin
        resp_valid_d = '0;
        resp_rdata_d = resp_rdata_q;
        if (transfer) begin
            resp_valid_d = req_ready;
            resp_rdata_d = req_we[sel] ? wdata_arr[sel] : rf_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid_q <= '0;
            resp_rdata_q <= '0;
        end else begin
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;

endmodule
